opb_frame_engine: RTL

OPB_FRAME_ENGINE -- requirements
Module: opb_frame_engine

---
 rtl/opb_frame_engine.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/opb_frame_engine.sv
// rtl/opb_frame_engine.sv - UART byte-frame to OPB bus bridge with echo response
`timescale 1ns/1ps
module opb_frame_engine #(
  parameter int ADDR_BYTES  = 4,
  parameter int DATA_BYTES  = 4,
  parameter int RX_TIMEOUT  = 20000,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic                    SYS_CLK,
  input  logic                    RESET_N,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [8*ADDR_BYTES-1:0] opb_addr,
  output logic [8*DATA_BYTES-1:0] opb_wdata,
  output logic                    opb_wr,
  output logic                    opb_rd,
  input  logic [8*DATA_BYTES-1:0] opb_rdata,
  input  logic                    opb_ack,
  output logic                    busy,
  output logic                    bus_err,
  output logic [7:0]              err_cnt
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int FL = 2 + ADDR_BYTES + DATA_BYTES;
  // Response bytes that follow the header: address, data, trailer
  localparam int RW = AW + DW + 8;
  localparam int TW = $clog2(RX_TIMEOUT + 1);
  localparam int BW = $clog2(BUS_TIMEOUT + 1);

  localparam logic [7:0] HDR_WR = 8'h5A;
  localparam logic [7:0] HDR_RD = 8'h5B;
  localparam logic [7:0] TRL_WR = 8'hA5;
  localparam logic [7:0] TRL_RD = 8'hA4;

  localparam logic [TW-1:0] RX_LAST   = TW'(RX_TIMEOUT - 1);
  localparam logic [BW-1:0] BUS_LAST  = BW'(BUS_TIMEOUT);
  localparam logic [3:0]    ADDR_LAST = 4'(ADDR_BYTES - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BYTES - 1);
  localparam logic [3:0]    RESP_REST = 4'(FL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_TAIL, S_BUS, S_BUS_WAIT, S_RESP
  } state_t;

  state_t          state;
  logic            is_read;
  logic [3:0]      cnt;
  logic [TW-1:0]   rx_timer;
  logic [BW-1:0]   wait_cnt;
  logic [AW-1:0]   addr_sr;
  logic [DW-1:0]   data_sr;
  logic [RW-1:0]   resp_sr;

  assign busy = (state != S_IDLE);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Bytes queued behind the header echo once the bus cycle completes
  function automatic logic [RW-1:0] resp_word(input logic [DW-1:0] d);
    return {opb_addr, d, (is_read ? TRL_RD : TRL_WR)};
  endfunction

  // Frame parser, bus sequencer and response serializer
  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      is_read   <= 1'b0;
      cnt       <= '0;
      rx_timer  <= '0;
      wait_cnt  <= '0;
      addr_sr   <= '0;
      data_sr   <= '0;
      resp_sr   <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      opb_addr  <= '0;
      opb_wdata <= '0;
      opb_wr    <= 1'b0;
      opb_rd    <= 1'b0;
      bus_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      opb_wr <= 1'b0;
      opb_rd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_valid && (rx_data == HDR_WR || rx_data == HDR_RD)) begin
            is_read  <= (rx_data == HDR_RD);
            cnt      <= '0;
            rx_timer <= '0;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            rx_timer <= '0;
            addr_sr  <= (addr_sr << 8) | AW'(rx_data);
            if (cnt == ADDR_LAST) begin
              cnt   <= '0;
              state <= S_DATA;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else if (rx_timer == RX_LAST) begin
            state   <= S_IDLE;
            err_cnt <= sat_inc(err_cnt);
          end else begin
            rx_timer <= rx_timer + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            rx_timer <= '0;
            data_sr  <= (data_sr << 8) | DW'(rx_data);
            if (cnt == DATA_LAST) begin
              cnt   <= '0;
              state <= S_TAIL;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else if (rx_timer == RX_LAST) begin
            state   <= S_IDLE;
            err_cnt <= sat_inc(err_cnt);
          end else begin
            rx_timer <= rx_timer + 1'b1;
          end
        end
        S_TAIL: begin
          if (rx_valid) begin
            rx_timer <= '0;
            if (rx_data == (is_read ? TRL_RD : TRL_WR)) begin
              // Strobe goes out the cycle right after the trailer byte
              opb_addr  <= addr_sr;
              opb_wdata <= data_sr;
              opb_wr    <= ~is_read;
              opb_rd    <= is_read;
              state     <= S_BUS;
            end else begin
              state   <= S_IDLE;
              err_cnt <= sat_inc(err_cnt);
            end
          end else if (rx_timer == RX_LAST) begin
            state   <= S_IDLE;
            err_cnt <= sat_inc(err_cnt);
          end else begin
            rx_timer <= rx_timer + 1'b1;
          end
        end
        S_BUS: begin
          if (opb_ack) begin
            bus_err  <= 1'b0;
            resp_sr  <= resp_word(is_read ? opb_rdata : opb_wdata);
            tx_data  <= is_read ? HDR_RD : HDR_WR;
            tx_valid <= 1'b1;
            cnt      <= RESP_REST;
            state    <= S_RESP;
          end else begin
            wait_cnt <= BW'(1);
            state    <= S_BUS_WAIT;
          end
        end
        S_BUS_WAIT: begin
          if (opb_ack || wait_cnt == BUS_LAST) begin
            bus_err  <= ~opb_ack;
            if (opb_ack)
              resp_sr <= resp_word(is_read ? opb_rdata : opb_wdata);
            else
              resp_sr <= resp_word(is_read ? {DW{1'b1}} : opb_wdata);
            tx_data  <= is_read ? HDR_RD : HDR_WR;
            tx_valid <= 1'b1;
            cnt      <= RESP_REST;
            state    <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (tx_ready) begin
            if (cnt == 4'd0) begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end else begin
              tx_data <= resp_sr[RW-1 -: 8];
              resp_sr <= resp_sr << 8;
              cnt     <= cnt - 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      // Bytes arriving while the bus or response is in progress are lost
      if (rx_valid && (state == S_BUS || state == S_BUS_WAIT || state == S_RESP))
        err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule
